// File: rtl/gate_sweep_unit.sv
// Truth-table sweeper: walks every WIDTH-bit input vector, applies a latched gate function
// to each, holds every sample for STEP_CYCLES cycles and counts the vectors that yield 1.
module gate_sweep_unit #(
  parameter int unsigned WIDTH       = 2,
  parameter int unsigned STEP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] input_vec,
  output logic             op,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   ones_count
);

  localparam int unsigned CntW = WIDTH + 1;
  localparam logic [7:0]  HoldLast = 8'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e     state_q;
  logic [2:0] mode_q;
  logic [7:0] hold_q;

  function automatic logic gate_fn(input logic [2:0] m, input logic [WIDTH-1:0] v);
    logic r;
    r = 1'b0;
    case (m)
      3'd0:    r = &v;
      3'd1:    r = |v;
      3'd2:    r = ~&v;
      3'd3:    r = ~|v;
      3'd4:    r = ^v;
      3'd5:    r = ~^v;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mode_q     <= 3'd0;
      hold_q     <= 8'd0;
      input_vec  <= '0;
      op         <= 1'b0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ones_count <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            state_q    <= StRun;
            mode_q     <= mode;
            hold_q     <= 8'd0;
            input_vec  <= '0;
            op         <= gate_fn(mode, '0);
            valid      <= 1'b1;
            busy       <= 1'b1;
            ones_count <= '0;
          end
        end
        StRun: begin
          if (hold_q == HoldLast) begin
            // Count once per vector, on the edge that retires it.
            hold_q     <= 8'd0;
            ones_count <= ones_count + CntW'(op);
            if (&input_vec) begin
              state_q <= StDone;
              valid   <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              input_vec <= input_vec + 1'b1;
              op        <= gate_fn(mode_q, input_vec + 1'b1);
            end
          end else begin
            hold_q <= hold_q + 8'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
